// File: rtl/kf8255_arb_pkg.sv
// Shared types and constants for the KF8255 access arbiter: FSM states, owner IDs, PPI addresses.
package kf8255_arb_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_RECOVER
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_P0,
        OWN_P1,
        OWN_INT
    } owner_t;

    localparam logic [1:0] PPI_PORT_A  = 2'd0;
    localparam logic [1:0] PPI_PORT_B  = 2'd1;
    localparam logic [1:0] PPI_PORT_C  = 2'd2;
    localparam logic [1:0] PPI_CONTROL = 2'd3;

    // Mode 0, port A in, port B out, port C in.
    localparam logic [7:0] INIT_CONTROL_WORD = 8'h99;

    // Down-counter load for an N-cycle phase; N below 1 collapses to a single cycle.
    function automatic logic [3:0] cycle_load(input int cycles);
        return (cycles <= 1) ? 4'd0 : 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/kf8255_arb_priority.sv
// Grant selection for the two requesters, port 0 preferred, with a saturating
// starvation counter that forces port 1 in after STARVE_LIMIT consecutive losses.
module kf8255_arb_priority
    import kf8255_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic idle,
    output logic grant_sel,
    output logic grant_valid
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign grant_valid = idle & (req0 | req1);
    assign grant_sel   = req1 & (~req0 | (starve_cnt == LIMIT));

    // Only IDLE cycles move the counter; port 0 wins only when req1 is also high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (idle) begin
            if (!req1 || grant_sel) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/kf8255_access_arbiter.sv
// Serialises two requesters onto one KF8255 register interface with SETUP/ACTIVE/RECOVER strobe timing.
// Optional KF8255_ARB_INIT_EN: after reset, write INIT_CONTROL_WORD to the control register before serving requests.
module kf8255_access_arbiter
    import kf8255_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] addr0,
    input  logic       wr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic [1:0] addr1,
    input  logic       wr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic [1:0] address,
    output logic [7:0] data_bus_out,
    input  logic [7:0] data_bus_in,
    output logic       busy
);

    localparam logic [3:0] ACC_LOAD    = cycle_load(ACCESS_CYCLES);
    localparam logic [3:0] REC_LOAD    = cycle_load(RECOVERY_CYCLES);
    localparam bit         HAS_RECOVER = (RECOVERY_CYCLES > 0);

`ifdef KF8255_ARB_INIT_EN
    localparam arb_state_t RESET_STATE = ST_INIT;
`else
    localparam arb_state_t RESET_STATE = ST_IDLE;
`endif

    arb_state_t state;
    owner_t     owner;
    logic [3:0] cycle_cnt;
    logic       cap_wr;
    logic       grant_sel;
    logic       grant_valid;

    kf8255_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clock       (clock),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .idle        (state == ST_IDLE),
        .grant_sel   (grant_sel),
        .grant_valid (grant_valid)
    );

    assign busy = (state != ST_IDLE);

    // address/data_bus_out double as the captured request and hold through ACTIVE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= RESET_STATE;
            owner          <= OWN_P0;
            cycle_cnt      <= 4'd0;
            cap_wr         <= 1'b0;
            chip_select_n  <= 1'b1;
            read_enable_n  <= 1'b1;
            write_enable_n <= 1'b1;
            address        <= 2'd0;
            data_bus_out   <= 8'd0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= 8'd0;
            rdata1         <= 8'd0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
`ifdef KF8255_ARB_INIT_EN
                ST_INIT: begin
                    owner         <= OWN_INT;
                    cap_wr        <= 1'b1;
                    address       <= PPI_CONTROL;
                    data_bus_out  <= INIT_CONTROL_WORD;
                    chip_select_n <= 1'b0;
                    state         <= ST_SETUP;
                end
`endif
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant_sel ? OWN_P1 : OWN_P0;
                        cap_wr        <= grant_sel ? wr1 : wr0;
                        address       <= grant_sel ? addr1 : addr0;
                        data_bus_out  <= grant_sel ? wdata1 : wdata0;
                        chip_select_n <= 1'b0;
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    read_enable_n  <= cap_wr;
                    write_enable_n <= ~cap_wr;
                    cycle_cnt      <= ACC_LOAD;
                    state          <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cycle_cnt == 4'd0) begin
                        chip_select_n  <= 1'b1;
                        read_enable_n  <= 1'b1;
                        write_enable_n <= 1'b1;
                        case (owner)
                            OWN_P0: begin
                                ack0 <= 1'b1;
                                if (!cap_wr) rdata0 <= data_bus_in;
                            end
                            OWN_P1: begin
                                ack1 <= 1'b1;
                                if (!cap_wr) rdata1 <= data_bus_in;
                            end
                            default: ;
                        endcase
                        if (HAS_RECOVER) begin
                            cycle_cnt <= REC_LOAD;
                            state     <= ST_RECOVER;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cycle_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cycle_cnt <= cycle_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kf8255_access_arbiter.sv
// Bench for kf8255_access_arbiter: directed scenarios plus a randomized run against a cycle-level bus model.
module tb_kf8255_access_arbiter;

    localparam int AC = 2;
    localparam int RC = 1;
    localparam int SL = 4;

`ifdef KF8255_ARB_INIT_EN
    localparam bit RST_BUSY = 1'b1;
`else
    localparam bit RST_BUSY = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
    logic [1:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0, data_bus_in = 0;
    logic       ack0, ack1, chip_select_n, read_enable_n, write_enable_n, busy;
    logic [7:0] rdata0, rdata1, data_bus_out;
    logic [1:0] address;

    logic       b_req0 = 0, b_wr0 = 0, b_req1 = 0, b_wr1 = 0;
    logic [1:0] b_addr0 = 0, b_addr1 = 0;
    logic [7:0] b_wdata0 = 0, b_wdata1 = 0, b_din = 0;
    logic       b_ack0, b_ack1, b_cs_n, b_re_n, b_we_n, b_busy;
    logic [7:0] b_rdata0, b_rdata1, b_dout;
    logic [1:0] b_address;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_rdata0_now = 8'h00;

    always #5 clock = ~clock;

    kf8255_access_arbiter #(.ACCESS_CYCLES(AC), .RECOVERY_CYCLES(RC), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .addr0(addr0), .wr0(wr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .wr1(wr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
        .address(address), .data_bus_out(data_bus_out), .data_bus_in(data_bus_in), .busy(busy)
    );

    kf8255_access_arbiter #(.ACCESS_CYCLES(AC), .RECOVERY_CYCLES(0), .STARVE_LIMIT(SL)) dut_r0 (
        .clock(clock), .reset(reset),
        .req0(b_req0), .addr0(b_addr0), .wr0(b_wr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .addr1(b_addr1), .wr1(b_wr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
        .chip_select_n(b_cs_n), .read_enable_n(b_re_n), .write_enable_n(b_we_n),
        .address(b_address), .data_bus_out(b_dout), .data_bus_in(b_din), .busy(b_busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (chip_select_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", chip_select_n); end
        n_cmp++; if (read_enable_n !== 1'b1) begin n_fail++; $display("FAIL rst_re_n: got %b want 1", read_enable_n); end
        n_cmp++; if (write_enable_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b want 1", write_enable_n); end
        n_cmp++; if (address !== 2'd0) begin n_fail++; $display("FAIL rst_address: got %0d want 0", address); end
        n_cmp++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %0h want 0", data_bus_out); end
        n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b want 00", {ack0, ack1}); end
        n_cmp++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %0h/%0h want 0/0", rdata0, rdata1); end
        n_cmp++; if (busy !== RST_BUSY) begin n_fail++; $display("FAIL rst_busy: got %b want %b", busy, RST_BUSY); end
        n_cmp++; if (b_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_b_cs_n: got %b want 1", b_cs_n); end
    endtask

`ifdef KF8255_ARB_INIT_EN
    task automatic test_init();
        int acc = 0, we1 = 0, re1 = 0, early = 0, acks = 0;
        bit prev_cs = 1, a_ok = 1, d_ok = 1;
        req0 = 1; addr0 = 2'd1; wr0 = 0; data_bus_in = 8'h11;
        @(negedge clock);
        reset = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (!chip_select_n && prev_cs) acc++;
            prev_cs = chip_select_n;
            if (acc == 1 && !chip_select_n) begin
                if (!write_enable_n) we1++;
                if (!read_enable_n) re1++;
                if (address !== 2'd3) a_ok = 0;
                if (data_bus_out !== 8'h99) d_ok = 0;
            end
            if (ack0) begin acks++; if (acc <= 1) early++; end
            @(posedge clock); #1;
            if (acks > 0) req0 = 0;
        end
        exp_rdata0_now = 8'h11;
        n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL init_accesses: got %0d want 2", acc); end
        n_cmp++; if (we1 !== AC || re1 !== 0) begin n_fail++; $display("FAIL init_strobes: got we %0d re %0d want %0d/0", we1, re1, AC); end
        n_cmp++; if (!a_ok || !d_ok) begin n_fail++; $display("FAIL init_word: addr_ok %b data_ok %b want 1/1", a_ok, d_ok); end
        n_cmp++; if (early !== 0 || acks !== 1) begin n_fail++; $display("FAIL init_ack: early %0d total %0d want 0/1", early, acks); end
        n_cmp++; if (rdata0 !== 8'h11) begin n_fail++; $display("FAIL init_rdata0: got %0h want 11", rdata0); end
    endtask
`endif

    task automatic test_single_read();
        int first_cs = -1, ack_at = -1, re_lo = 0, we_lo = 0, acks1 = 0, acks0 = 0;
        bit a_ok = 1;
        logic [7:0] got = 8'h00;
        req1 = 1; addr1 = 2'd1; wr1 = 0; wdata1 = 8'hEE; data_bus_in = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!chip_select_n && first_cs < 0) first_cs = k;
            if (!chip_select_n && address !== 2'd1) a_ok = 0;
            if (!read_enable_n) re_lo++;
            if (!write_enable_n) we_lo++;
            if (ack0) acks0++;
            if (ack1) begin acks1++; if (ack_at < 0) begin ack_at = k; got = rdata1; end end
            @(posedge clock); #1;
            if (ack_at >= 0) req1 = 0;
        end
        n_cmp++; if (re_lo !== AC || we_lo !== 0) begin n_fail++; $display("FAIL rd_strobes: got re %0d we %0d want %0d/0", re_lo, we_lo, AC); end
        n_cmp++; if (!a_ok) begin n_fail++; $display("FAIL rd_address: got mismatching address want 1"); end
        n_cmp++; if (acks1 !== 1 || acks0 !== 0) begin n_fail++; $display("FAIL rd_acks: got ack1 %0d ack0 %0d want 1/0", acks1, acks0); end
        n_cmp++; if (ack_at - first_cs !== 1 + AC) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", ack_at - first_cs, 1 + AC); end
        n_cmp++; if (got !== 8'h5A) begin n_fail++; $display("FAIL rd_rdata_at_ack: got %0h want 5a", got); end
        n_cmp++; if (rdata1 !== 8'h5A) begin n_fail++; $display("FAIL rd_rdata_hold: got %0h want 5a", rdata1); end
    endtask

    task automatic test_single_write();
        int we_lo = 0, re_lo = 0, acks0 = 0, acks1 = 0;
        bit d_ok = 1, a_ok = 1;
        req0 = 1; addr0 = 2'd3; wr0 = 1; wdata0 = 8'h82; data_bus_in = 8'hC3;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!chip_select_n && data_bus_out !== 8'h82) d_ok = 0;
            if (!chip_select_n && address !== 2'd3) a_ok = 0;
            if (!write_enable_n) we_lo++;
            if (!read_enable_n) re_lo++;
            if (ack0) acks0++;
            if (ack1) acks1++;
            @(posedge clock); #1;
            if (acks0 > 0) req0 = 0;
        end
        n_cmp++; if (we_lo !== AC || re_lo !== 0) begin n_fail++; $display("FAIL wr_strobes: got we %0d re %0d want %0d/0", we_lo, re_lo, AC); end
        n_cmp++; if (!d_ok || !a_ok) begin n_fail++; $display("FAIL wr_bus_stable: data_ok %b addr_ok %b want 1/1", d_ok, a_ok); end
        n_cmp++; if (acks0 !== 1 || acks1 !== 0) begin n_fail++; $display("FAIL wr_acks: got ack0 %0d ack1 %0d want 1/0", acks0, acks1); end
        n_cmp++; if (rdata0 !== exp_rdata0_now) begin n_fail++; $display("FAIL wr_rdata0_kept: got %0h want %0h", rdata0, exp_rdata0_now); end
    endtask

    task automatic test_contention();
        int order [10];
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int n = 0, both = 0;
        req0 = 1; addr0 = 2'd0; wr0 = 0; req1 = 1; addr1 = 2'd2; wr1 = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (ack0 && ack1) both++;
            if (ack0 && n < 10) begin order[n] = 0; n++; end
            if (ack1 && n < 10) begin order[n] = 1; n++; end
            @(posedge clock); #1;
            if (n >= 10) begin req0 = 0; req1 = 0; end
        end
        n_cmp++; if (n !== 10) begin n_fail++; $display("FAIL cont_count: got %0d grants want 10", n); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (i < n && order[i] !== exp_order[i]) begin n_fail++; $display("FAIL cont_order[%0d]: got port %0d want port %0d", i, order[i], exp_order[i]); end
        end
        n_cmp++; if (both !== 0) begin n_fail++; $display("FAIL cont_dual_ack: got %0d cycles want 0", both); end
    endtask

    task automatic test_reset_mid();
        int we_lo = 0, acks = 0, acks2 = 0, we2 = 0;
        bit hit = 0, d_ok = 1;
        req0 = 1; addr0 = 2'd0; wr0 = 1; wdata0 = 8'h3C;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clock);
            if (!write_enable_n) we_lo++;
            if (ack0) acks++;
            if (we_lo == 2) begin
                hit = 1;
                reset = 1;
                #1;
                n_cmp++; if (chip_select_n !== 1'b1 || write_enable_n !== 1'b1) begin n_fail++; $display("FAIL rmid_strobes: got cs %b we %b want 1/1", chip_select_n, write_enable_n); end
                n_cmp++; if (busy !== RST_BUSY) begin n_fail++; $display("FAIL rmid_busy: got %b want %b", busy, RST_BUSY); end
            end else begin
                @(posedge clock); #1;
            end
        end
        n_cmp++; if (!hit) begin n_fail++; $display("FAIL rmid_reach_active: got no second ACTIVE cycle want one"); end
        @(posedge clock);
        @(negedge clock);
        if (ack0) acks++;
        reset = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (!write_enable_n) we2++;
            if (!write_enable_n && data_bus_out !== 8'h3C) d_ok = 0;
            if (ack0) acks2++;
            @(posedge clock); #1;
            if (acks2 > 0) req0 = 0;
        end
        n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_dropped_ack: got %0d want 0", acks); end
        n_cmp++; if (acks2 !== 1 || we2 !== AC || !d_ok) begin n_fail++; $display("FAIL rmid_recover: got ack %0d we %0d data_ok %b want 1/%0d/1", acks2, we2, d_ok, AC); end
        n_cmp++; if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL rmid_rdata0: got %0h want 0", rdata0); end
    endtask

    task automatic test_random();
        int p = 0, starve = 0;
        bit have = 0, t_own = 0, t_wr = 0, in_bus, active, idle_now, e_ack0, e_ack1, a0_seen, a1_seen;
        logic [1:0] t_addr = 0;
        logic [7:0] t_wdata = 0, sampled = 0, exp_rd0 = 0, exp_rd1 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            in_bus = have && p >= 1 && p <= 1 + AC;
            active = have && p >= 2 && p <= 1 + AC;
            if (have && p == 1 + AC && !t_wr) sampled = data_bus_in;
            e_ack0 = have && p == 2 + AC && !t_own;
            e_ack1 = have && p == 2 + AC && t_own;
            if (e_ack0 && !t_wr) exp_rd0 = sampled;
            if (e_ack1 && !t_wr) exp_rd1 = sampled;
            n_cmp++; if (chip_select_n !== !in_bus) begin n_fail++; $display("FAIL rnd_cs_n @%0d: got %b want %b", cyc, chip_select_n, !in_bus); end
            n_cmp++; if (read_enable_n !== !(active && !t_wr)) begin n_fail++; $display("FAIL rnd_re_n @%0d: got %b want %b", cyc, read_enable_n, !(active && !t_wr)); end
            n_cmp++; if (write_enable_n !== !(active && t_wr)) begin n_fail++; $display("FAIL rnd_we_n @%0d: got %b want %b", cyc, write_enable_n, !(active && t_wr)); end
            n_cmp++; if (ack0 !== e_ack0 || ack1 !== e_ack1) begin n_fail++; $display("FAIL rnd_ack @%0d: got %b%b want %b%b", cyc, ack0, ack1, e_ack0, e_ack1); end
            n_cmp++; if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin n_fail++; $display("FAIL rnd_rdata @%0d: got %0h/%0h want %0h/%0h", cyc, rdata0, rdata1, exp_rd0, exp_rd1); end
            if (in_bus) begin
                n_cmp++; if (address !== t_addr || data_bus_out !== t_wdata) begin n_fail++; $display("FAIL rnd_bus @%0d: got %0d/%0h want %0d/%0h", cyc, address, data_bus_out, t_addr, t_wdata); end
            end
            idle_now = !have || p >= 2 + AC + RC;
            n_cmp++; if (busy !== !idle_now) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, busy, !idle_now); end
            a0_seen = ack0;
            a1_seen = ack1;
            if (idle_now) begin
                if (req0 || req1) begin
                    t_own = req1 && (!req0 || starve == SL);
                    t_addr  = t_own ? addr1 : addr0;
                    t_wr    = t_own ? wr1 : wr0;
                    t_wdata = t_own ? wdata1 : wdata0;
                    have = 1;
                    p = 0;
                end
                if (!req1 || t_own) starve = 0;
                else if (starve < SL) starve++;
            end
            if (have) p++;
            @(posedge clock); #1;
            if (req0 && a0_seen) begin
                if ($urandom_range(1, 0) == 0) req0 = 0;
                else begin addr0 = 2'($urandom); wr0 = 1'($urandom); wdata0 = 8'($urandom); end
            end else if (!req0 && $urandom_range(3, 0) == 0) begin
                req0 = 1; addr0 = 2'($urandom); wr0 = 1'($urandom); wdata0 = 8'($urandom);
            end
            if (req1 && a1_seen) begin
                if ($urandom_range(1, 0) == 0) req1 = 0;
                else begin addr1 = 2'($urandom); wr1 = 1'($urandom); wdata1 = 8'($urandom); end
            end else if (!req1 && $urandom_range(3, 0) == 0) begin
                req1 = 1; addr1 = 2'($urandom); wr1 = 1'($urandom); wdata1 = 8'($urandom);
            end
            data_bus_in = 8'($urandom);
        end
        req0 = 0; req1 = 0;
        drain(15);
    endtask

    task automatic test_back_to_back();
        int falls [3];
        int nf = 0, gap_hi = 0, re_lo = 0, acks = 0;
        bit prev_cs = 1, gap_busy_bad = 0;
        b_req0 = 1; b_addr0 = 2'd2; b_wr0 = 0; b_din = 8'hA5;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (!b_cs_n && prev_cs && nf < 3) begin falls[nf] = k; nf++; end
            if (nf >= 1 && nf < 3 && b_cs_n) begin gap_hi++; if (b_busy !== 1'b0) gap_busy_bad = 1; end
            prev_cs = b_cs_n;
            if (nf >= 1 && nf < 3 && !b_re_n) re_lo++;
            if (b_ack0) acks++;
        end
        @(posedge clock); #1;
        b_req0 = 0;
        drain(10);
        n_cmp++; if (nf !== 3) begin n_fail++; $display("FAIL b2b_accesses: got %0d want 3", nf); end
        n_cmp++; if (nf == 3 && (falls[1] - falls[0] !== 4 || falls[2] - falls[1] !== 4)) begin n_fail++; $display("FAIL b2b_period: got %0d,%0d want 4,4", falls[1] - falls[0], falls[2] - falls[1]); end
        n_cmp++; if (gap_hi !== 2 || gap_busy_bad) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles busy_bad %b want 2/0", gap_hi, gap_busy_bad); end
        n_cmp++; if (re_lo !== 2 * AC) begin n_fail++; $display("FAIL b2b_re_lo: got %0d want %0d", re_lo, 2 * AC); end
        n_cmp++; if (acks < 6 || b_rdata0 !== 8'hA5) begin n_fail++; $display("FAIL b2b_acks: got %0d acks rdata %0h want >=6/a5", acks, b_rdata0); end
    endtask

    initial begin
        test_reset();
`ifdef KF8255_ARB_INIT_EN
        test_init();
`else
        @(negedge clock);
        reset = 0;
        drain(2);
`endif
        test_single_read();
        test_single_write();
        test_contention();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
